// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings, controller
// state type and the value returned for the reserved opcode.
package seq_alu_pkg;

  localparam logic [3:0] OP_AND    = 4'b0000;
  localparam logic [3:0] OP_OR     = 4'b0001;
  localparam logic [3:0] OP_NEG    = 4'b0010;
  localparam logic [3:0] OP_NOT    = 4'b0011;
  localparam logic [3:0] OP_ADD    = 4'b0100;
  localparam logic [3:0] OP_SUB    = 4'b0101;
  localparam logic [3:0] OP_MUL    = 4'b0110;
  localparam logic [3:0] OP_DIV    = 4'b0111;
  localparam logic [3:0] OP_SHR    = 4'b1000;
  localparam logic [3:0] OP_SHRA   = 4'b1001;
  localparam logic [3:0] OP_SHL    = 4'b1010;
  localparam logic [3:0] OP_ROR    = 4'b1011;
  localparam logic [3:0] OP_ROL    = 4'b1100;
  localparam logic [3:0] OP_INC    = 4'b1101;
  localparam logic [3:0] OP_BRANCH = 4'b1110;
  localparam logic [3:0] OP_RSVD   = 4'b1111;

  // Value driven on both result words for the reserved opcode (sliced to WIDTH).
  localparam logic [63:0] RSVD_RESULT = 64'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/seq_alu_divider.sv
// Signed iterative non-restoring divider. Works on operand magnitudes and
// fixes signs at the end: quotient truncates toward zero, remainder follows
// the dividend. start loads the operands; WIDTH iteration cycles follow and
// done is raised during the last one, with quotient/remainder valid alongside.
module seq_alu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH);

  logic                    active_p;
  logic [CW-1:0]           cnt_p;
  logic signed [WIDTH+1:0] rem_p;
  logic [WIDTH-1:0]        quo_p;
  logic [WIDTH-1:0]        dvs_p;
  logic                    qneg_p;
  logic                    rneg_p;

  logic signed [WIDTH+1:0] shifted;
  logic signed [WIDTH+1:0] dvs_ext;
  logic signed [WIDTH+1:0] trial;
  logic [WIDTH-1:0]        quo_nxt;
  logic [WIDTH-1:0]        mag_r;

  // One non-restoring step plus final remainder restore and sign fix-up.
  always_comb begin
    shifted  = $signed({rem_p[WIDTH:0], quo_p[WIDTH-1]});
    dvs_ext  = $signed({2'b00, dvs_p});
    trial    = rem_p[WIDTH+1] ? shifted + dvs_ext : shifted - dvs_ext;
    quo_nxt  = {quo_p[WIDTH-2:0], ~trial[WIDTH+1]};
    mag_r    = WIDTH'(trial[WIDTH+1] ? trial + dvs_ext : trial);
    quotient  = qneg_p ? -quo_nxt : quo_nxt;
    remainder = rneg_p ? -mag_r : mag_r;
    done      = active_p && (cnt_p == CW'(WIDTH - 1));
  end

  // Iteration control: armed by start, released after the last step.
  always_ff @(posedge clock) begin
    if (clear) begin
      active_p <= 1'b0;
      cnt_p    <= '0;
    end else if (start) begin
      active_p <= 1'b1;
      cnt_p    <= '0;
    end else if (active_p) begin
      cnt_p <= cnt_p + CW'(1);
      if (done) active_p <= 1'b0;
    end
  end

  // Datapath: load magnitudes and signs on start, then shift/add-subtract.
  always_ff @(posedge clock) begin
    if (start) begin
      rem_p  <= '0;
      quo_p  <= dividend[WIDTH-1] ? -dividend : dividend;
      dvs_p  <= divisor[WIDTH-1] ? -divisor : divisor;
      qneg_p <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      rneg_p <= dividend[WIDTH-1];
    end else if (active_p) begin
      rem_p <= trial;
      quo_p <= quo_nxt;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith/shift ops, iterative signed Booth
// multiply, and (when SEQ_ALU_DIV_EN is defined) an iterative signed divide
// through seq_alu_divider. Without SEQ_ALU_DIV_EN the divide opcode completes
// in one cycle with zero results.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero
);

  localparam int SW = $clog2(WIDTH);

  state_t           state;
  logic [SW-1:0]    cnt_p;
  logic [SW-1:0]    amt;
  logic [WIDTH-1:0] alu_lo;
  logic [WIDTH-1:0] alu_hi;
  logic             alu_dbz;
  logic             div_accept;
  logic             div_done;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;

  // Booth multiplier state: accumulator carries two guard bits.
  logic signed [WIDTH+1:0] acc_p;
  logic [WIDTH-1:0]        mq_p;
  logic                    qm1_p;
  logic signed [WIDTH-1:0] mcand_p;
  logic signed [WIDTH+1:0] mcand_ext;
  logic signed [WIDTH+1:0] booth_sum;
  logic signed [WIDTH+1:0] acc_nxt;
  logic [WIDTH-1:0]        mq_nxt;
  logic                    mul_last;

  assign amt      = b[SW-1:0];
  assign mul_last = (cnt_p == SW'(WIDTH - 1));

`ifdef SEQ_ALU_DIV_EN
  assign div_accept = (op == OP_DIV) && (b != '0);

  seq_alu_divider #(.WIDTH(WIDTH)) u_divider (
    .clock     (clock),
    .clear     (clear),
    .start     ((state == IDLE) && start && div_accept),
    .dividend  (a),
    .divisor   (b),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );
`else
  assign div_accept = 1'b0;
  assign div_done   = 1'b0;
  assign div_quo    = '0;
  assign div_rem    = '0;
`endif

  // Single-cycle result decode from the live operands at accept time.
  always_comb begin
    alu_lo  = '0;
    alu_hi  = '0;
    alu_dbz = 1'b0;
    case (op)
      OP_AND:    alu_lo = a & b;
      OP_OR:     alu_lo = a | b;
      OP_NEG:    alu_lo = -a;
      OP_NOT:    alu_lo = ~a;
      OP_ADD:    alu_lo = a + b;
      OP_SUB:    alu_lo = a - b;
      OP_MUL:    alu_lo = '0;
`ifdef SEQ_ALU_DIV_EN
      OP_DIV: begin
        if (b == '0) begin
          alu_lo  = '1;
          alu_hi  = a;
          alu_dbz = 1'b1;
        end
      end
`else
      OP_DIV:    alu_lo = '0;
`endif
      OP_SHR:    alu_lo = a >> amt;
      OP_SHRA:   alu_lo = $unsigned($signed(a) >>> amt);
      OP_SHL:    alu_lo = a << amt;
      OP_ROR:    alu_lo = WIDTH'({a, a} >> amt);
      OP_ROL:    alu_lo = WIDTH'(({a, a} << amt) >> WIDTH);
      OP_INC:    alu_lo = b + WIDTH'(1);
      OP_BRANCH: alu_lo = a + b;
      default: begin
        alu_lo = RSVD_RESULT[WIDTH-1:0];
        alu_hi = RSVD_RESULT[WIDTH-1:0];
      end
    endcase
  end

  // Radix-2 Booth step: add/subtract multiplicand, then arithmetic shift right.
  always_comb begin
    mcand_ext = $signed({{2{mcand_p[WIDTH-1]}}, mcand_p});
    case ({mq_p[0], qm1_p})
      2'b01:   booth_sum = acc_p + mcand_ext;
      2'b10:   booth_sum = acc_p - mcand_ext;
      default: booth_sum = acc_p;
    endcase
    acc_nxt = {booth_sum[WIDTH+1], booth_sum[WIDTH+1:1]};
    mq_nxt  = {booth_sum[0], mq_p[WIDTH-1:1]};
  end

  // Multiplier datapath: load on accept, iterate while in MUL.
  always_ff @(posedge clock) begin
    if ((state == IDLE) && start && (op == OP_MUL)) begin
      acc_p   <= '0;
      mq_p    <= b;
      qm1_p   <= 1'b0;
      mcand_p <= $signed(a);
    end else if (state == MUL) begin
      acc_p <= acc_nxt;
      mq_p  <= mq_nxt;
      qm1_p <= mq_p[0];
    end
  end

  // Controller: accept, iterate, publish results with a one-cycle done.
  always_ff @(posedge clock) begin
    if (clear) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      result_lo   <= '0;
      result_hi   <= '0;
      div_by_zero <= 1'b0;
      cnt_p       <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (op == OP_MUL) begin
              state <= MUL;
              busy  <= 1'b1;
              cnt_p <= '0;
            end else if (div_accept) begin
              state <= DIV;
              busy  <= 1'b1;
            end else begin
              state       <= DONE;
              done        <= 1'b1;
              result_lo   <= alu_lo;
              result_hi   <= alu_hi;
              div_by_zero <= alu_dbz;
            end
          end
        end
        MUL: begin
          cnt_p <= cnt_p + SW'(1);
          if (mul_last) begin
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            result_lo   <= mq_nxt;
            result_hi   <= acc_nxt[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
        end
        DIV: begin
          if (div_done) begin
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            result_lo   <= div_quo;
            result_hi   <= div_rem;
            div_by_zero <= 1'b0;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=32). Divide expectations follow whether
// SEQ_ALU_DIV_EN is defined for this build.
module tb_seq_alu;

  localparam int W = 32;

`ifdef SEQ_ALU_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         clear;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result_lo;
  logic [W-1:0] result_hi;
  logic         div_by_zero;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string      tag;
    logic [3:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic       dbz;
    int         lat;
  } vec_t;

  vec_t vq[$];

  seq_alu #(.WIDTH(W)) dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .result_lo   (result_lo),
    .result_hi   (result_hi),
    .div_by_zero (div_by_zero)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic add(input string tag, input logic [3:0] o, input logic [31:0] va,
                     input logic [31:0] vb, input logic [31:0] lo, input logic [31:0] hi,
                     input logic dbz, input int lat);
    vec_t v;
    v.tag = tag; v.op = o; v.a = va; v.b = vb;
    v.lo = lo; v.hi = hi; v.dbz = dbz; v.lat = lat;
    vq.push_back(v);
  endtask

  task automatic add_div(input string tag, input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] lo, input logic [31:0] hi, input logic dbz,
                         input int lat);
    if (DIV_ON) add(tag, 4'b0111, va, vb, lo, hi, dbz, lat);
    else        add(tag, 4'b0111, va, vb, 32'h0, 32'h0, 1'b0, 1);
  endtask

  // Issue one op, scramble inputs after accept, wait (bounded) for done.
  task automatic run_vec(input vec_t v);
    int lat;
    int bcyc;
    start = 1'b1; op = v.op; a = v.a; b = v.b;
    tick();
    start = 1'b0; op = 4'b0100; a = ~v.a; b = v.b ^ 32'h5A5A_0001;
    lat = 1;
    bcyc = 0;
    while (!done && lat < 100) begin
      if (busy) bcyc++;
      tick();
      lat++;
    end
    if (!done) begin
      check({v.tag, "_timeout"}, 64'(done), 64'(1'b1));
      return;
    end
    check({v.tag, "_lat"}, 64'(lat), 64'(v.lat));
    check({v.tag, "_lo"}, 64'(result_lo), 64'(v.lo));
    check({v.tag, "_hi"}, 64'(result_hi), 64'(v.hi));
    check({v.tag, "_dbz"}, 64'(div_by_zero), 64'(v.dbz));
    check({v.tag, "_busy_at_done"}, 64'(busy), 64'(1'b0));
    check({v.tag, "_busy_cycles"}, 64'(bcyc), 64'(v.lat - 1));
    tick();
    check({v.tag, "_done_pulse"}, 64'(done), 64'(1'b0));
    check({v.tag, "_lo_held"}, 64'(result_lo), 64'(v.lo));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    clear = 1'b1; start = 1'b0; op = 4'h0; a = '0; b = '0;
    tick();
    tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_lo", 64'(result_lo), 64'd0);
    check("rst_hi", 64'(result_hi), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    clear = 1'b0;

    add("add_ovf",  4'b0100, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 32'h0, 1'b0, 1);
    add("mul_neg",  4'b0110, 32'hFFFF_FFFD, 32'h7, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0, 33);
    add_div("div_neg", 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
    add_div("div_zero", 32'h5, 32'h0, 32'hFFFF_FFFF, 32'h5, 1'b1, 1);
    add("mul_min",  4'b0110, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h4000_0000, 1'b0, 33);
    add("mul_max",  4'b0110, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h1, 32'h3FFF_FFFF, 1'b0, 33);
    add("ror",      4'b1011, 32'h1, 32'h21, 32'h8000_0000, 32'h0, 1'b0, 1);
    add_div("div_pos", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
    add_div("div_nd",  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 33);
    add_div("div_nv",  32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0, 33);
    add_div("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0, 33);
    add("and",      4'b0000, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 32'h0, 1'b0, 1);
    add("or",       4'b0001, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 32'h0, 1'b0, 1);
    add("neg",      4'b0010, 32'h1, 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b0, 1);
    add("not",      4'b0011, 32'h0F0F_0F0F, 32'h0, 32'hF0F0_F0F0, 32'h0, 1'b0, 1);
    add("sub",      4'b0101, 32'h3, 32'h5, 32'hFFFF_FFFE, 32'h0, 1'b0, 1);
    add("shr",      4'b1000, 32'h8000_0000, 32'h3F, 32'h1, 32'h0, 1'b0, 1);
    add("shra_neg", 4'b1001, 32'h8000_0000, 32'h1F, 32'hFFFF_FFFF, 32'h0, 1'b0, 1);
    add("shra_pos", 4'b1001, 32'h4000_0000, 32'h2, 32'h1000_0000, 32'h0, 1'b0, 1);
    add("shl_wrap", 4'b1010, 32'h1, 32'h20, 32'h1, 32'h0, 1'b0, 1);
    add("rol",      4'b1100, 32'h8000_0001, 32'h4, 32'h18, 32'h0, 1'b0, 1);
    add("inc_wrap", 4'b1101, 32'h1234, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0, 1);
    add("branch",   4'b1110, 32'h10, 32'h20, 32'h30, 32'h0, 1'b0, 1);
    add("rsvd",     4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0, 1);

    foreach (vq[i]) run_vec(vq[i]);

    // Start held high through a multiply and its done cycle must be ignored.
    start = 1'b1; op = 4'b0110; a = 32'd3; b = 32'd5;
    tick();
    op = 4'b0100; a = 32'd100; b = 32'd100;
    lat = 1;
    while (!done && lat < 100) begin
      tick();
      lat++;
    end
    start = 1'b0;
    check("busy_ign_lat", 64'(lat), 64'd33);
    check("busy_ign_lo", 64'(result_lo), 64'd15);
    check("busy_ign_hi", 64'(result_hi), 64'd0);
    tick();
    check("busy_ign_done0", 64'(done), 64'd0);
    tick();
    check("busy_ign_done1", 64'(done), 64'd0);
    check("busy_ign_held", 64'(result_lo), 64'd15);

    // Clear ten cycles into a multiply aborts it; next-cycle start accepted.
    start = 1'b1; op = 4'b0110; a = 32'd3; b = 32'd7;
    tick();
    start = 1'b0;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) lat++;
      tick();
    end
    check("abort_no_done_pre", 64'(lat), 64'd0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_lo", 64'(result_lo), 64'd0);
    check("abort_hi", 64'(result_hi), 64'd0);
    check("abort_dbz", 64'(div_by_zero), 64'd0);
    start = 1'b1; op = 4'b0100; a = 32'd2; b = 32'd3;
    tick();
    start = 1'b0;
    check("post_clr_done", 64'(done), 64'd1);
    check("post_clr_lo", 64'(result_lo), 64'd5);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) lat++;
    end
    check("abort_no_late_done", 64'(lat), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter: WIDTH, 32, operand width in bits; legal values are powers of two from 8 to 64.
REQ-002 Port: clock  in  1  single clock; all state updates on the rising edge.
REQ-003 Port: clear  in  1  reset, synchronous and active-high.
REQ-004 Port: start  in  1  request; sampled only in IDLE.
REQ-005 Port: op  in  4  opcode, captured with start.
REQ-006 Port: a  in  WIDTH  operand A (Y side; dividend for DIV), captured with start.
REQ-007 Port: b  in  WIDTH  operand B (bus side; divisor or shift/rotate count), captured with start.
REQ-008 Port: busy  out  1  high from the cycle after accept until done.
REQ-009 Port: done  out  1  one-cycle pulse; results are valid in that cycle and held afterwards.
REQ-010 Port: result_lo  out  WIDTH  low word, or quotient for DIV.
REQ-011 Port: result_hi  out  WIDTH  high word of MUL, remainder for DIV, otherwise 0.
REQ-012 Port: div_by_zero  out  1  registered flag, valid with done.

Function
REQ-013 Opcodes SHALL be decoded as follows:
- 0000 AND, 0001 OR, 0010 NEG(a), 0011 NOT(a)
- 0100 ADD, 0101 SUB(a-b), 0110 MUL, 0111 DIV
- 1000 SHR, 1001 SHRA, 1010 SHL, 1011 ROR, 1100 ROL
- 1101 INC(b+1), 1110 BRANCH(a+b)
- 1111 reserved; results are 0.
REQ-014 The FSM SHALL have the states IDLE, MUL, DIV and DONE. From IDLE, start goes to MUL, DIV or DONE according to op. MUL and DIV go to DONE after WIDTH iteration cycles. DONE goes to IDLE.
REQ-015 For a start accepted on edge k, single-cycle ops SHALL assert done in cycle k+1, and MUL/DIV SHALL assert done in cycle k+WIDTH+1.
REQ-016 start while busy or done is high SHALL be ignored. Operands and op SHALL be latched on accept, so later input changes have no effect.
REQ-017 Add, subtract and increment SHALL be modulo 2^WIDTH, with no carry output. For these ops result_hi SHALL be 0.
REQ-018 Shifts and rotates SHALL use only b[log2(WIDTH)-1:0]. SHRA SHALL replicate a[WIDTH-1].
REQ-019 MUL SHALL be a signed two's-complement iterative multiply giving the 2*WIDTH-bit product {result_hi,result_lo}.
REQ-020 DIV SHALL be signed, iterative and non-restoring. The quotient SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-021 DIV with b==0 SHALL complete as a single-cycle op with result_lo all-ones, result_hi=a and div_by_zero=1. div_by_zero SHALL be 0 for every other completion.
REQ-022 Results and div_by_zero SHALL hold their values until the next done.

Reset
REQ-023 With clear high, the next edge SHALL set the state to IDLE, busy=0, done=0, result_lo=0, result_hi=0 and div_by_zero=0.
REQ-024 clear SHALL take priority over start and abort any operation in flight without a done pulse.
REQ-025 start SHALL be accepted in the first cycle after clear deasserts.

Configuration
REQ-026 Macro SEQ_ALU_DIV_EN:
- Defined: DIV behaves as REQ-020 and REQ-021.
- Undefined: the divider SHALL be absent, and op 0111 SHALL complete in one cycle with results 0 and div_by_zero=0.

Structure
REQ-027 Package seq_alu_pkg SHALL hold the opcode constants, the FSM state typedef and the reserved-op result constant.
REQ-028 The iterative divide datapath SHALL be a sub-module, seq_alu_divider, with start/done handshake, instantiated only under SEQ_ALU_DIV_EN.
REQ-029 The multiply datapath SHALL be implemented inside seq_alu.

Verification
REQ-030 The bench SHALL cover the following directed scenarios, with WIDTH=32 and SEQ_ALU_DIV_EN defined:
- ADD a=0x7FFFFFFF, b=1 -> result_lo=0x80000000, result_hi=0, done at k+1.
- MUL a=0xFFFFFFFD, b=7 -> result_hi=0xFFFFFFFF, result_lo=0xFFFFFFEB, done at k+33, busy high for 32 cycles.
- DIV a=0xFFFFFFF9, b=2 -> result_lo=0xFFFFFFFD, result_hi=0xFFFFFFFF, div_by_zero=0.
- DIV a=5, b=0 -> result_lo=0xFFFFFFFF, result_hi=5, div_by_zero=1, done at k+1.
- ROR a=1, b=0x21 -> result_lo=0x80000000; a second start while busy is ignored.
- clear asserted 10 cycles into a MUL -> no done, all outputs 0; ADD 2+3 accepted next cycle -> result_lo=5.
